destination_v2: RTL

//  Parametrised valid/ready sink: captures data_in beats into a DEPTH-entry buffer, with ready throttled by an

---
 rtl/dest_pkg.sv | 20 ++
 rtl/destination_v2_bit_sync.sv | 25 ++
 rtl/destination_v2.sv | 103 ++++++++++
 3 files changed

// File: rtl/dest_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dest_pkg : ready-mode / wrap-mode constants and count-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package dest_pkg;

  localparam int RDY_AFTER_VALID = 0;
  localparam int RDY_FREE        = 1;

  localparam int WR_STOP = 0;
  localparam int WR_WRAP = 1;

  // Occupancy counter must be able to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/destination_v2_bit_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_sync : STAGES-deep single-bit synchroniser with async active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/destination_v2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// destination_v2 : valid/ready sink capturing beats into a DEPTH-entry buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module destination_v2
  import dest_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 256,
  parameter int READY_MODE  = RDY_AFTER_VALID,
  parameter int WRAP        = WR_STOP,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic                     idle,
  input  logic                     clear,
  input  logic                     valid,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ready,
  output logic                     full,
  output logic [cnt_w(DEPTH)-1:0]  wr_count,
  output logic                     overflow,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = cnt_w(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam bit            WRAP_EN   = (WRAP == WR_WRAP);
  localparam bit            FREE_RDY  = (READY_MODE == RDY_FREE);

  logic             idle_s;
  logic [AW-1:0]    wr_addr, wr_addr_nxt, wr_ptr;
  logic [CW-1:0]    wr_count_nxt;
  logic             xfer, at_last, stop, rd_hit;
  logic             ready_nxt, full_nxt, overflow_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  bit_sync #(.STAGES(SYNC_STAGES)) u_idle_sync (
    .clk  (clk),
    .rst_n(s_rst_n),
    .d    (idle),
    .q    (idle_s)
  );

  always_comb begin
    xfer         = valid & ready;
    at_last      = (wr_addr == LAST_ADDR);
    // A clear redirects a coincident beat to entry 0 so it is not lost.
    wr_ptr       = clear ? '0 : wr_addr;
    stop         = ~clear & (full | (xfer & at_last & ~WRAP_EN));
    ready_nxt    = (FREE_RDY | valid) & idle_s & ~stop;
    rd_hit       = (CW'(rd_addr) < wr_count);
    wr_addr_nxt  = wr_addr;
    wr_count_nxt = wr_count;
    full_nxt     = full;
    overflow_nxt = overflow;
    if (clear) begin
      wr_addr_nxt  = xfer ? AW'(1) : '0;
      wr_count_nxt = xfer ? CW'(1) : '0;
      full_nxt     = 1'b0;
      overflow_nxt = 1'b0;
    end else begin
      if (xfer) begin
        if (!at_last)     wr_addr_nxt = wr_addr + 1'b1;
        else if (WRAP_EN) wr_addr_nxt = '0;
        if (wr_count != DEPTH_CNT) wr_count_nxt = wr_count + 1'b1;
        // Count already at DEPTH means this beat lands on live data.
        if (WRAP_EN && wr_count == DEPTH_CNT) overflow_nxt = 1'b1;
        if (!WRAP_EN && at_last)              full_nxt     = 1'b1;
      end
      if (!WRAP_EN && full && valid) overflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ready    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
      wr_count <= '0;
      wr_addr  <= '0;
      rd_data  <= '0;
    end else begin
      ready    <= ready_nxt;
      full     <= full_nxt;
      overflow <= overflow_nxt;
      wr_count <= wr_count_nxt;
      wr_addr  <= wr_addr_nxt;
      rd_data  <= rd_hit ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= data_in;
  end

endmodule
`default_nettype wire
